// File: rtl/weight_bank_sequencer.sv
// Bank controller: host single-word writes, windowed read stream, bulk zero-clear.
// Stream: first word 2 cycles after start; output register holds while out_valid && !out_ready.
module weight_bank_sequencer #(
   parameter int DATA_W = 17,
   parameter int ADDR_W = 6
) (
   input  logic              CLOCK_50,
   input  logic              RESET_N,
   input  logic              host_wr_req,
   input  logic [ADDR_W-1:0] host_wr_addr,
   input  logic [DATA_W-1:0] host_wr_data,
   output logic              host_wr_ack,
   input  logic              clear,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] len,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_wr_address,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic [ADDR_W-1:0] mem_rd_address,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_index,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, CLEAR} state_t;

   state_t            state, state_d;
   logic [ADDR_W-1:0] idx, idx_d;
   logic [ADDR_W-1:0] len_r, len_d;

   logic              host_wr_ack_d;
   logic              mem_wr_d;
   logic [ADDR_W-1:0] mem_wr_address_d;
   logic [DATA_W-1:0] mem_wr_data_d;
   logic [ADDR_W-1:0] mem_rd_address_d;
   logic              out_valid_d;
   logic [DATA_W-1:0] out_data_d;
   logic [ADDR_W-1:0] out_index_d;
   logic              out_last_d;
   logic              busy_d;
   logic              done_d;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state          <= IDLE;
         idx            <= '0;
         len_r          <= '0;
         host_wr_ack    <= 1'b0;
         mem_wr         <= 1'b0;
         mem_wr_address <= '0;
         mem_wr_data    <= '0;
         mem_rd_address <= '0;
         out_valid      <= 1'b0;
         out_data       <= '0;
         out_index      <= '0;
         out_last       <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         state          <= state_d;
         idx            <= idx_d;
         len_r          <= len_d;
         host_wr_ack    <= host_wr_ack_d;
         mem_wr         <= mem_wr_d;
         mem_wr_address <= mem_wr_address_d;
         mem_wr_data    <= mem_wr_data_d;
         mem_rd_address <= mem_rd_address_d;
         out_valid      <= out_valid_d;
         out_data       <= out_data_d;
         out_index      <= out_index_d;
         out_last       <= out_last_d;
         busy           <= busy_d;
         done           <= done_d;
      end
   end

   always_comb begin
      state_d          = state;
      idx_d            = idx;
      len_d            = len_r;
      host_wr_ack_d    = 1'b0;
      mem_wr_d         = 1'b0;
      mem_wr_address_d = mem_wr_address;
      mem_wr_data_d    = mem_wr_data;
      mem_rd_address_d = mem_rd_address;
      out_valid_d      = out_valid;
      out_data_d       = out_data;
      out_index_d      = out_index;
      out_last_d       = out_last;
      busy_d           = busy;
      done_d           = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_d          = RUN;
               busy_d           = 1'b1;
               idx_d            = '0;
               len_d            = len;
               mem_rd_address_d = base_addr;
            end else if (clear) begin
               state_d          = CLEAR;
               busy_d           = 1'b1;
               mem_wr_d         = 1'b1;
               mem_wr_address_d = '0;
               mem_wr_data_d    = '0;
            end else if (host_wr_req && !host_wr_ack) begin
               // the ack cycle blocks re-acceptance of a still-held request
               mem_wr_d         = 1'b1;
               mem_wr_address_d = host_wr_addr;
               mem_wr_data_d    = host_wr_data;
               host_wr_ack_d    = 1'b1;
            end
         end

         RUN: begin
            if (!out_valid || out_ready) begin
               out_data_d       = mem_rd_data;
               out_index_d      = idx;
               out_last_d       = (idx == len_r);
               out_valid_d      = 1'b1;
               idx_d            = idx + 1'b1;
               mem_rd_address_d = mem_rd_address + 1'b1;
               if (idx == len_r)
                  state_d = FLUSH;
            end
         end

         FLUSH: begin
            if (out_valid && out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               done_d      = 1'b1;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end
         end

         CLEAR: begin
            if (mem_wr_address == '1) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               mem_wr_d         = 1'b1;
               mem_wr_address_d = mem_wr_address + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_weight_bank_sequencer.sv
// Directed bench for weight_bank_sequencer with a behavioural 64 x 17 bank.
module tb_weight_bank_sequencer;

   logic        CLOCK_50;
   logic        RESET_N;
   logic        host_wr_req;
   logic [5:0]  host_wr_addr;
   logic [16:0] host_wr_data;
   logic        host_wr_ack;
   logic        clear;
   logic        start;
   logic [5:0]  base_addr;
   logic [5:0]  len;
   logic        mem_wr;
   logic [5:0]  mem_wr_address;
   logic [16:0] mem_wr_data;
   logic [5:0]  mem_rd_address;
   logic [16:0] mem_rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [16:0] out_data;
   logic [5:0]  out_index;
   logic        out_last;
   logic        busy;
   logic        done;

   int total = 0;
   int bad   = 0;

   logic [16:0] bank [64];
   logic [16:0] wrap_exp [4];

   weight_bank_sequencer #(.DATA_W(17), .ADDR_W(6)) dut (
      .CLOCK_50       (CLOCK_50),
      .RESET_N        (RESET_N),
      .host_wr_req    (host_wr_req),
      .host_wr_addr   (host_wr_addr),
      .host_wr_data   (host_wr_data),
      .host_wr_ack    (host_wr_ack),
      .clear          (clear),
      .start          (start),
      .base_addr      (base_addr),
      .len            (len),
      .mem_wr         (mem_wr),
      .mem_wr_address (mem_wr_address),
      .mem_wr_data    (mem_wr_data),
      .mem_rd_address (mem_rd_address),
      .mem_rd_data    (mem_rd_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_index      (out_index),
      .out_last       (out_last),
      .busy           (busy),
      .done           (done)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   // bank is filled with a nonzero pattern while reset is held
   always @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         for (int i = 0; i < 64; i++)
            bank[i] <= 17'h15555 ^ 17'(i);
      end else if (mem_wr) begin
         bank[mem_wr_address] <= mem_wr_data;
      end
   end
   assign mem_rd_data = bank[mem_rd_address];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic write_word(input logic [5:0] a, input logic [16:0] d);
      host_wr_req  = 1'b1;
      host_wr_addr = a;
      host_wr_data = d;
      step();
      chk("wr_ack", host_wr_ack, 1);
      chk("wr_en", mem_wr, 1);
      chk("wr_addr", mem_wr_address, a);
      chk("wr_data", mem_wr_data, d);
      host_wr_req = 1'b0;
      step();
      chk("wr_ack_pulse", host_wr_ack, 0);
      chk("wr_en_pulse", mem_wr, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int exp_i;
      int stalls;

      RESET_N = 1'b0;
      host_wr_req = 1'b0; host_wr_addr = '0; host_wr_data = '0;
      clear = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b0;
      wrap_exp[0] = 17'd200; wrap_exp[1] = 17'd201;
      wrap_exp[2] = 17'd100; wrap_exp[3] = 17'd101;

      repeat (3) @(posedge CLOCK_50);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_ack", host_wr_ack, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_addr", mem_rd_address, 0);
      chk("rst_out_data", out_data, 0);
      RESET_N = 1'b1;
      step();
      chk("post_rst_busy", busy, 0);

      // host writes k+100 to 0..7, plus markers at 62/63
      for (int k = 0; k < 8; k++)
         write_word(6'(k), 17'(100 + k));
      write_word(6'd62, 17'd200);
      write_word(6'd63, 17'd201);

      // read pass base=0 len=7, ready held high
      out_ready = 1'b1; base_addr = 6'd0; len = 6'd7; start = 1'b1;
      step();
      start = 1'b0;
      chk("run_busy", busy, 1);
      chk("run_first_addr", mem_rd_address, 0);
      chk("run_no_valid_c1", out_valid, 0);
      for (int k = 0; k < 8; k++) begin
         step();
         chk("run_valid", out_valid, 1);
         chk("run_data", out_data, 100 + k);
         chk("run_index", out_index, k);
         chk("run_last", out_last, (k == 7));
         chk("run_done_early", done, 0);
      end
      step();
      chk("run_done", done, 1);
      chk("run_busy_end", busy, 0);
      chk("run_valid_end", out_valid, 0);
      step();
      chk("run_done_pulse", done, 0);

      // wrap past 63
      base_addr = 6'd62; len = 6'd3; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("wrap_addr", mem_rd_address, (62 + k) % 64);
         step();
         chk("wrap_index", out_index, k);
         chk("wrap_data", out_data, wrap_exp[k]);
         chk("wrap_last", out_last, (k == 3));
      end
      step();
      chk("wrap_done", done, 1);

      // backpressure: ready low for cycles 4..6 while index 2 is presented
      base_addr = 6'd0; len = 6'd7; start = 1'b1;
      step();
      start = 1'b0;
      c = 1; exp_i = 0; stalls = 0;
      while (c < 40 && done !== 1'b1) begin
         out_ready = (c < 4 || c > 6);
         if (out_valid && out_ready) begin
            chk("bp_accept_idx", out_index, exp_i);
            chk("bp_accept_data", out_data, 100 + exp_i);
            exp_i++;
         end else if (out_valid) begin
            chk("bp_hold_idx", out_index, 2);
            chk("bp_hold_data", out_data, 102);
            chk("bp_hold_addr", mem_rd_address, 3);
            stalls++;
         end
         step();
         c++;
      end
      out_ready = 1'b1;
      chk("bp_done", done, 1);
      chk("bp_done_cycle", c, 13);
      chk("bp_word_count", exp_i, 8);
      chk("bp_stall_count", stalls, 3);

      // start and write request together: the pass wins, write waits for IDLE
      base_addr = 6'd0; len = 6'd1; start = 1'b1;
      host_wr_req = 1'b1; host_wr_addr = 6'd5; host_wr_data = 17'd77;
      step();
      start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         chk("cont_ack_blocked", host_wr_ack, 0);
         chk("cont_mem_wr_blocked", mem_wr, 0);
         if (k < 4) step();
      end
      chk("cont_done", done, 1);
      step();
      chk("cont_ack", host_wr_ack, 1);
      chk("cont_wr_en", mem_wr, 1);
      chk("cont_wr_addr", mem_wr_address, 5);
      chk("cont_wr_data", mem_wr_data, 77);

      // pass started during the ack cycle reads the freshly written word
      host_wr_req = 1'b0; base_addr = 6'd5; len = 6'd0; start = 1'b1;
      step();
      start = 1'b0;
      chk("raw_ack_gone", host_wr_ack, 0);
      chk("raw_busy", busy, 1);
      chk("raw_addr", mem_rd_address, 5);
      step();
      chk("raw_valid", out_valid, 1);
      chk("raw_data", out_data, 77);
      chk("raw_last", out_last, 1);
      chk("raw_index", out_index, 0);
      step();
      chk("raw_done", done, 1);

      // asynchronous reset in the middle of a stalled pass
      base_addr = 6'd0; len = 6'd7; out_ready = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("mid_pre_valid", out_valid, 1);
      chk("mid_pre_data", out_data, 100);
      RESET_N = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_index", out_index, 0);
      chk("mid_rst_addr", mem_rd_address, 0);
      @(posedge CLOCK_50);
      @(posedge CLOCK_50);
      #1;
      RESET_N = 1'b1;
      out_ready = 1'b1;
      step();
      chk("mid_post_busy", busy, 0);
      chk("mid_post_valid", out_valid, 0);
      step();
      chk("mid_post_busy2", busy, 0);

      // bulk clear then full-bank read
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_busy", busy, 1);
      for (int k = 1; k <= 64; k++) begin
         chk("clr_wr_en", mem_wr, 1);
         chk("clr_wr_addr", mem_wr_address, k - 1);
         chk("clr_wr_data", mem_wr_data, 0);
         step();
      end
      chk("clr_done", done, 1);
      chk("clr_wr_off", mem_wr, 0);
      chk("clr_busy_end", busy, 0);

      base_addr = 6'd0; len = 6'd63; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 64; k++) begin
         step();
         chk("clr_rd_data", out_data, 0);
         chk("clr_rd_index", out_index, k);
      end
      step();
      chk("clr_rd_done", done, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
